// File: rtl/ebr_recovery_ctrl_pkg.sv
// Shared types and constants for the early-branch-recovery checkpoint control
// and the checkpoint store it drives.
package ebr_recovery_ctrl_pkg;

  localparam int unsigned EbrNum   = 4;
  localparam int unsigned RobDepth = 16;
  localparam int unsigned RobTagW  = $clog2(RobDepth) + 1;

  typedef enum logic [1:0] {
    SlotFree,
    SlotPend,
    SlotOk
  } slot_e;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRedirect
  } fsm_e;

endpackage

// File: rtl/ebr_recovery_ctrl_if.sv
// Rename / branch-unit / front-end signal bundle of the checkpoint controller.
// The master modport is the controller side.
interface ebr_recovery_ctrl_if import ebr_recovery_ctrl_pkg::*; #(
  parameter int unsigned EBR_NUM = EbrNum,
  parameter int unsigned PC_W    = 32
);
  localparam int unsigned IdxW = $clog2(EBR_NUM);

  logic              snap_req;
  logic              snap_gnt;
  logic [IdxW-1:0]   snap_idx;
  logic              resolve_valid;
  logic              resolve_ready;
  logic [IdxW-1:0]   resolve_idx;
  logic              resolve_mispred;
  logic [PC_W-1:0]   resolve_target;
  logic              early_flush;
  logic              up;
  logic [IdxW-1:0]   ebr_idx;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              redirect_ready;
  logic              ebr_full;
  logic [IdxW:0]     ebr_count;

  modport master (
    input  snap_req, resolve_valid, resolve_idx, resolve_mispred, resolve_target,
    input  redirect_ready,
    output snap_gnt, snap_idx, resolve_ready, early_flush, up, ebr_idx,
    output redirect_valid, redirect_pc, ebr_full, ebr_count
  );

  modport slave (
    output snap_req, resolve_valid, resolve_idx, resolve_mispred, resolve_target,
    output redirect_ready,
    input  snap_gnt, snap_idx, resolve_ready, early_flush, up, ebr_idx,
    input  redirect_valid, redirect_pc, ebr_full, ebr_count
  );

endinterface

// File: rtl/ebr_age_tracker.sv
// Checkpoint slot states, allocation/oldest pointers, live count, in-order
// retirement and freeing of slots younger than a mispredicted branch.
module ebr_age_tracker import ebr_recovery_ctrl_pkg::*; #(
  parameter int unsigned EBR_NUM = EbrNum,
  localparam int unsigned IdxW   = $clog2(EBR_NUM),
  localparam int unsigned CntW   = IdxW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc,
  input  logic            res_valid,
  input  logic            res_mispred,
  input  logic [IdxW-1:0] res_idx,
  output logic [IdxW-1:0] alloc_ptr,
  output logic [CntW-1:0] count,
  output logic            full
);

  slot_e           slot_q [EBR_NUM];
  slot_e           slot_d [EBR_NUM];
  logic [IdxW-1:0] alloc_q, alloc_d, oldest_q, oldest_d, oldest_n, res_age;
  logic [CntW-1:0] count_q, count_d;
  logic            retire;
  logic [EBR_NUM-1:0] younger;

  // Ages are measured from the oldest live slot so a full ring is unambiguous.
  always_comb begin
    retire   = (count_q != '0) && (slot_q[oldest_q] == SlotOk);
    oldest_n = oldest_q + IdxW'(retire);
    res_age  = res_idx - oldest_q;
    for (int i = 0; i < EBR_NUM; i++) begin
      logic [IdxW-1:0] age;
      age        = IdxW'(i) - oldest_q;
      younger[i] = (age > res_age) && (CntW'(age) < count_q);
    end
  end

  always_comb begin
    slot_d   = slot_q;
    alloc_d  = alloc_q;
    oldest_d = oldest_n;
    count_d  = count_q + CntW'(alloc) - CntW'(retire);
    if (retire) slot_d[oldest_q] = SlotFree;
    if (alloc) begin
      slot_d[alloc_q] = SlotPend;
      alloc_d         = alloc_q + IdxW'(1);
    end
    if (res_valid) slot_d[res_idx] = SlotOk;
    if (res_mispred) begin
      for (int i = 0; i < EBR_NUM; i++) begin
        if (younger[i]) slot_d[i] = SlotFree;
      end
      alloc_d = res_idx + IdxW'(1);
      count_d = CntW'(IdxW'(res_idx - oldest_n)) + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < EBR_NUM; i++) slot_q[i] <= SlotFree;
      alloc_q  <= '0;
      oldest_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      alloc_q  <= alloc_d;
      oldest_q <= oldest_d;
      count_q  <= count_d;
    end
  end

  assign alloc_ptr = alloc_q;
  assign count     = count_q;
  assign full      = (count_q == CntW'(EBR_NUM));

endmodule

// File: rtl/ebr_recovery_ctrl.sv
// Early-branch-recovery control: checkpoint grants, resolution handling,
// flush/release pulses and the fetch redirect handshake.
module ebr_recovery_ctrl import ebr_recovery_ctrl_pkg::*; #(
  parameter int unsigned EBR_NUM   = EbrNum,
  parameter int unsigned ROB_DEPTH = RobDepth,
  parameter int unsigned PC_W      = 32
) (
  input logic                 clk,
  input logic                 rst,
  ebr_recovery_ctrl_if.master bus
);
  localparam int unsigned IdxW = $clog2(EBR_NUM);
  localparam int unsigned CntW = IdxW + 1;

  if (((EBR_NUM & (EBR_NUM - 1)) != 0) || (EBR_NUM < 2) || (ROB_DEPTH < EBR_NUM)) begin : g_bad_cfg
    $error("EBR_NUM must be a power of 2 >= 2 and no larger than ROB_DEPTH");
  end

  fsm_e            state_q, state_d;
  logic            accept, accept_mis, full;
  logic [IdxW-1:0] alloc_ptr, ebr_idx_q;
  logic [CntW-1:0] count;
  logic            up_q;
  logic [PC_W-1:0] pc_q;

  assign accept     = bus.resolve_valid & bus.resolve_ready;
  assign accept_mis = accept & bus.resolve_mispred;

  ebr_age_tracker #(
    .EBR_NUM(EBR_NUM)
  ) u_age_tracker (
    .clk        (clk),
    .rst        (rst),
    .alloc      (bus.snap_gnt),
    .res_valid  (accept),
    .res_mispred(accept_mis),
    .res_idx    (bus.resolve_idx),
    .alloc_ptr  (alloc_ptr),
    .count      (count),
    .full       (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept_mis) state_d = StFlush;
      StFlush:    state_d = StRedirect;
      StRedirect: if (bus.redirect_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // A mispredict offered in the same cycle wins over a new checkpoint.
  always_comb begin
    bus.resolve_ready  = (state_q == StIdle);
    bus.snap_gnt       = (state_q == StIdle) & bus.snap_req & ~full
                         & ~(bus.resolve_valid & bus.resolve_mispred);
    bus.early_flush    = (state_q == StFlush);
    bus.redirect_valid = (state_q == StRedirect);
    bus.up             = up_q;
    bus.ebr_idx        = ebr_idx_q;
    bus.redirect_pc    = pc_q;
    bus.snap_idx       = alloc_ptr;
    bus.ebr_full       = full;
    bus.ebr_count      = count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_q      <= 1'b0;
      ebr_idx_q <= '0;
      pc_q      <= '0;
    end else begin
      up_q <= accept & ~bus.resolve_mispred;
      if (accept)     ebr_idx_q <= bus.resolve_idx;
      if (accept_mis) pc_q      <= bus.resolve_target;
    end
  end

endmodule

// File: doc/ebr_recovery_ctrl.md
Name: ebr_recovery_ctrl

Overview:
- Control side of the early-branch-recovery checkpoint store.
- Grants checkpoint allocation to rename, accepts branch resolutions from the branch unit (out of order) and tracks checkpoint age order.
- On a correct prediction, pulses a release for that checkpoint. On a misprediction, pulses a flush with the recovery index, frees younger checkpoints, then redirects fetch.
- Sits between the branch execute unit / CDB, the checkpoint store and the front end.

Parameters:
EBR_NUM, 4, number of checkpoints; must be a power of 2
ROB_DEPTH, 16, ROB entries; tags are $clog2(ROB_DEPTH)+1 bits
PC_W, 32, redirect target width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
snap_req  in  1  rename has a branch needing a checkpoint
snap_gnt  out  1  checkpoint granted this cycle (combinational)
snap_idx  out  $clog2(EBR_NUM)  slot granted (equals alloc_ptr)
resolve_valid  in  1  branch resolution offered
resolve_ready  out  1  controller accepts resolution (combinational)
resolve_idx  in  $clog2(EBR_NUM)  checkpoint slot of the resolving branch
resolve_mispred  in  1  misprediction flag
resolve_target  in  PC_W  correct next PC
early_flush  out  1  one-cycle flush pulse to the checkpoint store and pipeline
up  out  1  one-cycle release pulse for a correctly predicted checkpoint
ebr_idx  out  $clog2(EBR_NUM)  index for early_flush or up (shared)
redirect_valid  out  1  fetch redirect request
redirect_pc  out  PC_W  redirect target
redirect_ready  in  1  front end accepts redirect
ebr_full  out  1  all checkpoints in use
ebr_count  out  $clog2(EBR_NUM)+1  live checkpoints

Behaviour:
- Reset (asserted low, async):
  - FSM=IDLE; alloc_ptr=0; oldest_ptr=0; count=0; all slots FREE.
  - Outputs early_flush, up, redirect_valid, ebr_full = 0; ebr_idx, redirect_pc, ebr_count = 0.
- Slot states: FREE, PEND, OK. Pointers wrap mod EBR_NUM. count width is $clog2(EBR_NUM)+1; ebr_full = (count==EBR_NUM).
- FSM IDLE:
  - resolve_ready=1.
  - snap_gnt = snap_req & ~ebr_full & ~(resolve_valid & resolve_mispred).
  - On grant: slot[alloc_ptr]=PEND, alloc_ptr++, count++.
- Resolution accepted (resolve_valid & resolve_ready) at cycle t:
  - Correct prediction: slot=OK; at t+1 up=1, ebr_idx=resolve_idx (registered); stay IDLE.
  - Misprediction: at t+1 FSM=FLUSH with early_flush=1, ebr_idx=resolve_idx.
    - Slot resolve_idx becomes OK.
    - Every slot strictly younger (resolve_idx+1 .. alloc_ptr-1, wrapped) becomes FREE.
    - alloc_ptr=resolve_idx+1; count=((resolve_idx-oldest_ptr) mod EBR_NUM)+1.
    - Any snap_req in cycle t is refused.
- FLUSH: lasts exactly 1 cycle, then REDIRECT. resolve_ready=0, snap_gnt=0.
- REDIRECT:
  - redirect_valid=1, redirect_pc = registered target, held stable until redirect_ready.
  - On the handshake cycle: redirect_valid drops next cycle and FSM returns to IDLE.
  - resolve_ready=0, snap_gnt=0.
- Retirement (every state):
  - If count!=0 and slot[oldest_ptr]==OK: slot=FREE, oldest_ptr++, count--. At most one per cycle.
  - Same-cycle grant and retire: count unchanged.
  - Same-cycle mispredict and retire: count formula uses the post-retire oldest_ptr.
- up and early_flush never assert in the same cycle.
- Both outputs are single-cycle pulses; at most one resolution is accepted per cycle.
- Resolution for a slot not in PEND is illegal; the bench asserts it never occurs.
- Mispredict for the oldest slot: alloc_ptr=oldest_ptr+1, count=1; that slot retires the next cycle.
- Reset mid-FLUSH or mid-REDIRECT returns to the reset state immediately; no redirect is issued.

Decomposition:
- Shared package: slot state enum (FREE/PEND/OK), FSM state enum (IDLE/FLUSH/REDIRECT), and EBR_NUM / ROB_DEPTH constants shared with the checkpoint store.
- One sub-module, ebr_age_tracker: slot state vector, alloc/oldest pointers, count, retirement logic, younger-slot free mask.
- The top level holds the FSM and output registers.

Test Plan:
- Four snap_req grants from reset -> snap_idx 0,1,2,3; ebr_count=4, ebr_full=1; a fifth snap_req -> snap_gnt=0.
- Slots 0-3 PEND; resolve slot 2 correct, then slot 0 correct -> up pulses with ebr_idx=2, then ebr_idx=0; slot 0 retires; count=3; slot 1 still PEND blocks retirement of slot 2.
- Slots 0-3 PEND; mispredict slot 1, target 0x8000_0040 ->
  - next cycle early_flush=1, ebr_idx=1.
  - Slots 2,3 FREE; alloc_ptr=2; count=2.
  - Redirect handshake: redirect_valid=1, redirect_pc=0x8000_0040.
- REDIRECT with redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable, resolve_ready=0; handshake on cycle 6 -> IDLE next cycle.
- Wrap-around: oldest_ptr=3, alloc_ptr=1 (slots 3,0 live); mispredict slot 3 -> alloc_ptr=0, slot 0 FREE, count=1.
- Same cycle snap_req and mispredict -> snap_gnt=0. Reset asserted during FLUSH -> all outputs 0, count=0, no redirect_valid afterwards.
